// File: rtl/word_packer_pkg.sv
// Shared sizing and state encoding for the word packer and the downstream 8-to-1 word select mux.
// Optional feature macro: WORD_PACKER_PARITY_EN (adds per-slot parity output).
package word_packer_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned BANK_W = WIDTH * DEPTH;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/word_slot.sv
// One bank slot: WIDTH-bit register with clear, write and zero-pad (priority in that order).
// With WORD_PACKER_PARITY_EN the slot also keeps the XOR reduction of its stored word.
module word_slot
  import word_packer_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             we,
  input  logic             pad,
  input  logic [WIDTH-1:0] d,
`ifdef WORD_PACKER_PARITY_EN
  output logic             par,
`endif
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end else if (pad) begin
      q <= '0;
    end
  end

`ifdef WORD_PACKER_PARITY_EN
  // Parity tracks the slot contents; cleared and padded slots read as parity 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par <= 1'b0;
    end else if (clr) begin
      par <= 1'b0;
    end else if (we) begin
      par <= ^d;
    end else if (pad) begin
      par <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/word_packer_8x32.sv
// Serial-to-parallel staging buffer: packs eight 32-bit words into a flat 256-bit bank and holds it until ack.
// Optional feature macro: WORD_PACKER_PARITY_EN (adds out_parity[7:0], even parity per slot).
module word_packer_8x32
  import word_packer_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              clear,
  output logic [BANK_W-1:0] out_bank,
  output logic              out_valid,
  input  logic              out_ack,
`ifdef WORD_PACKER_PARITY_EN
  output logic [DEPTH-1:0]  out_parity,
`endif
  output logic [CNT_W-1:0]  out_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   cnt_acc;
  logic               accept;
  logic               clr;
  logic [DEPTH-1:0]   we;
  logic [DEPTH-1:0]   pad;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state, count and per-slot write/pad strobes; clear overrides everything.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cnt_acc = count_q;
    accept  = 1'b0;
    clr     = 1'b0;
    we      = '0;
    pad     = '0;
    if (clear) begin
      state_d = FILL;
      count_d = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        FILL: begin
          accept = in_valid;
          if (accept) begin
            cnt_acc = count_q + CNT_W'(1);
          end
          for (int unsigned k = 0; k < DEPTH; k++) begin
            we[k] = accept && (count_q == CNT_W'(k));
          end
          count_d = cnt_acc;
          if (cnt_acc == CNT_W'(DEPTH)) begin
            state_d = FULL;
          end else if (flush && (cnt_acc != '0)) begin
            // Padding starts after any word written on this same edge.
            state_d = FULL;
            for (int unsigned k = 0; k < DEPTH; k++) begin
              pad[k] = (CNT_W'(k) >= cnt_acc);
            end
          end
        end
        FULL: begin
          if (out_ack) begin
            state_d = FILL;
            count_d = '0;
          end
        end
        default: begin
          state_d = FILL;
          count_d = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign out_count = count_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    word_slot u_slot (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr),
      .we     (we[k]),
      .pad    (pad[k]),
      .d      (in_data),
`ifdef WORD_PACKER_PARITY_EN
      .par    (out_parity[k]),
`endif
      .q      (out_bank[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_word_packer_8x32.sv
// Directed bench for word_packer_8x32 with a bank scoreboard; define WORD_PACKER_PARITY_EN to cover parity.
module tb_word_packer_8x32;
  import word_packer_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              clear = 1'b0;
  logic [255:0]      out_bank;
  logic              out_valid;
  logic              out_ack = 1'b0;
  logic [3:0]        out_count;
`ifdef WORD_PACKER_PARITY_EN
  logic [7:0]        out_parity;
`endif

  typedef struct packed {
    logic [255:0] bank;
    logic [3:0]   count;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mslot [8];
  int          mcnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  word_packer_8x32 dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .clear     (clear),
    .out_bank  (out_bank),
    .out_valid (out_valid),
    .out_ack   (out_ack),
`ifdef WORD_PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_bank();
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = mslot[k];
    return b;
  endfunction

  // Drive one word (optionally with flush); expected bank is queued when the bank closes.
  task automatic send(input logic [31:0] w, input logic fl);
    mslot[mcnt] = w;
    mcnt++;
    if (mcnt == 8 || fl) begin
      for (int k = mcnt; k < 8; k++) mslot[k] = '0;
      sb.push_back('{bank: model_bank(), count: 4'(mcnt)});
    end
    in_data  = w;
    in_valid = 1'b1;
    flush    = fl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic flush_only();
    for (int k = mcnt; k < 8; k++) mslot[k] = '0;
    sb.push_back('{bank: model_bank(), count: 4'(mcnt)});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    mcnt = 0;
  endtask

  // Bounded wait for a presented bank, then compare against the oldest queued expectation.
  task automatic pop_check(input string tag);
    int   n = 0;
    exp_t e;
    while (out_valid !== 1'b1 && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 256'(out_valid), 256'(1'b1));
    chk({tag, "_sbsize"}, 256'(sb.size()), 256'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_bank"}, out_bank, e.bank);
      chk({tag, "_count"}, 256'(out_count), 256'(e.count));
    end
    chk({tag, "_ready"}, 256'(in_ready), 256'(1'b0));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mslot[k] = '0;

    // Reset values
    #12;
    chk("rst_bank", out_bank, 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_count", 256'(out_count), 256'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 256'(in_ready), 256'(1'b1));

    // Back-to-back fill of 8 words
    for (int k = 1; k <= 8; k++) begin
      send(32'h1111_1111 * 32'(k), 1'b0);
      chk($sformatf("fill_valid_%0d", k), 256'(out_valid), 256'(k == 8));
    end
    chk("fill_slot0", 256'(out_bank[31:0]), 256'(32'h1111_1111));
    chk("fill_slot7", 256'(out_bank[255:224]), 256'(32'h8888_8888));
    pop_check("fill8");

    // Inputs ignored while FULL
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    flush    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_bank_%0d", c), out_bank, model_bank());
      chk($sformatf("hold_count_%0d", c), 256'(out_count), 256'(8));
    end
    flush = 1'b0;
    ack();
    in_valid = 1'b0;
    chk("ack_ready", 256'(in_ready), 256'(1'b1));
    chk("ack_count", 256'(out_count), 256'(0));
    chk("ack_valid", 256'(out_valid), 256'(1'b0));
    chk("ack_retain", 256'(out_bank[31:0]), 256'(32'h1111_1111));

    // Flush together with the 5th accept; stale slots 5..7 must be padded; ack in FILL ignored
    send(32'h5000_0001, 1'b0);
    chk("slot0_after_ack", 256'(out_bank[31:0]), 256'(32'h5000_0001));
    chk("count_after_first", 256'(out_count), 256'(1));
    send(32'h5000_0002, 1'b0);
    out_ack = 1'b1;
    send(32'h5000_0003, 1'b0);
    out_ack = 1'b0;
    chk("ack_in_fill_count", 256'(out_count), 256'(3));
    send(32'h5000_0004, 1'b0);
    send(32'h5000_0005, 1'b1);
    pop_check("flush5");
    ack();

    // Three words then a standalone flush
    send(32'hA0A0_A0A0, 1'b0);
    send(32'hB1B1_B1B1, 1'b0);
    send(32'hC2C2_C2C2, 1'b0);
    flush_only();
    pop_check("flush3");
    chk("flush3_upper", 256'(out_bank[255:96]), 256'(0));
    ack();

    // Flush with an empty bank is ignored
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush0_valid", 256'(out_valid), 256'(1'b0));
    chk("flush0_ready", 256'(in_ready), 256'(1'b1));
    chk("flush0_count", 256'(out_count), 256'(0));
    chk("flush0_bank", out_bank, model_bank());

    // Clear with a concurrent accept discards everything
    for (int k = 0; k < 5; k++) send(32'h7700_0000 + 32'(k), 1'b0);
    chk("pre_clear_count", 256'(out_count), 256'(5));
    in_data  = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) mslot[k] = '0;
    mcnt = 0;
    chk("clear_bank", out_bank, model_bank());
    chk("clear_count", 256'(out_count), 256'(0));
    chk("clear_ready", 256'(in_ready), 256'(1'b1));
    chk("clear_valid", 256'(out_valid), 256'(1'b0));

`ifdef WORD_PACKER_PARITY_EN
    // Alternating odd/even parity words
    for (int k = 0; k < 8; k++) send((k % 2 == 0) ? 32'h0000_0001 : 32'h0000_0003, 1'b0);
    pop_check("parity_fill");
    chk("parity", 256'(out_parity), 256'(8'b0101_0101));
    ack();
`endif

    // Random full bank, then asynchronous reset while FULL
    for (int k = 0; k < 8; k++) send($urandom, 1'b0);
    pop_check("rand_fill");
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 256'(out_valid), 256'(1'b0));
    chk("async_rst_bank", out_bank, 256'(0));
    chk("async_rst_count", 256'(out_count), 256'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 256'(in_ready), 256'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/word_packer_8x32.md
Name: word_packer_8x32

Overview:
- Serial-to-parallel staging buffer upstream of the 8-to-1 word select mux.
- Accepts 32-bit words one at a time over a valid/ready handshake and stores them in slots 0..7.
- Presents all eight slots as one flat 256-bit bus: slot k occupies bits [32k+31:32k].
- Signals when the bank is complete, holds it stable while the downstream selector reads it, then re-arms on acknowledge.

Parameters:
- WIDTH, 32, bits per word.
- DEPTH, 8, number of slots; fixed to match the 3-bit downstream select.
- CNT_W, 4, width of the fill counter; must represent 0..DEPTH.

Ports:
- Clk  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- In_Data  in  32  word to store.
- In_Valid  in  1  In_Data is valid this cycle.
- In_Ready  out  1  block can accept a word this cycle.
- Flush  in  1  close a partial bank: zero-pad the unfilled slots and present the bank.
- Clear  in  1  synchronous discard of the bank contents and the count.
- Out_Bank  out  256  flat bank; connects to the mux data input.
- Out_Valid  out  1  bank complete and stable.
- Out_Ack  in  1  consumer is done with the bank.
- Out_Count  out  4  number of real (non-pad) words in the bank, 0..8.

Behaviour:
- Interface: one clock, Clk. Reset is asynchronous and active-low, on Resetn.
- Reset (Resetn=0, asynchronous):
  - state=FILL, count=0, all slots=0.
  - Out_Bank=0, Out_Valid=0, Out_Count=0, In_Ready=1 once reset is released.
- States:
  - FILL: In_Ready=1, Out_Valid=0.
  - FULL: In_Ready=0, Out_Valid=1.
- Outputs: In_Ready and Out_Valid are decoded from the state register only, with no combinational path from inputs. Out_Bank and Out_Count are direct register outputs.
- Accept: In_Valid & In_Ready at a rising edge.
  - Slot[count] <= In_Data, count <= count+1.
  - The word is visible on Out_Bank the next cycle.
- FILL -> FULL:
  - When the accepted word is the 8th (count was 7); count becomes 8.
  - Or when Flush=1 with count>=1: slots count..7 <= 0 in the same edge, count unchanged. If a word is accepted on that edge, it is written first and padding starts at the next slot.
- Flush with count=0 (including when no word is accepted on that edge): ignored, stay in FILL.
- FULL -> FILL when Out_Ack=1: count <= 0. Slot contents are retained until overwritten.
  - In_Valid during the ack cycle is not accepted, because In_Ready=0 that cycle.
  - In_Valid during the following cycle is accepted into slot 0.
- In FULL: Out_Bank, Out_Count and Out_Valid are frozen; In_Valid and Flush are ignored.
- Out_Ack while in FILL: ignored.
- Clear (highest synchronous priority, either state):
  - Next state=FILL, count=0, all slots=0.
  - An accept, Flush or Ack on the same edge is discarded.
- Reset mid-fill or mid-hold: all state is lost immediately, regardless of the clock.
- Latency:
  - In_Valid & In_Ready at the edge completing the 8th accept -> Out_Valid=1 after that edge.
  - Out_Ack -> In_Ready=1 after the ack edge.
- Throughput: 8 words per bank plus 1 ack cycle; at most 1 word per cycle.

Optional Feature:
- Macro: WORD_PACKER_PARITY_EN.
- Defined:
  - Extra output Out_Parity [7:0]; bit k is the even parity (XOR reduction) of slot k.
  - Registered alongside the slot write; pad slots have parity 0; Clear and reset give 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Shared package/header `word_packer_pkg`:
  - WIDTH, DEPTH, CNT_W and the bank width WIDTH*DEPTH, shared with the mux.
  - State encodings: FILL=1'b0, FULL=1'b1.
- Sub-module `word_slot`: one WIDTH-bit register with write enable, clear and zero-pad, instantiated DEPTH times with a generate loop.
- The FSM and counter stay in the top.

Test Plan:
- Reset then 8 accepts of 32'h1111_1111*k (k=1..8) back-to-back:
  - Out_Valid=1 the cycle after the 8th accept.
  - Out_Bank[31:0]=32'h1111_1111, Out_Bank[255:224]=32'h8888_8888, Out_Count=8, In_Ready=0.
- While FULL, drive In_Valid=1 with In_Data=32'hDEAD_BEEF for 3 cycles:
  - Out_Bank unchanged.
  - Out_Ack pulse -> next cycle In_Ready=1, Out_Count=0; next accept lands in slot 0.
- Accept 3 words (A,B,C) then Flush:
  - Out_Valid=1, Out_Count=3.
  - Slots 0..2=A,B,C; Out_Bank[255:96]=0.
- Flush with count=0: no state change.
- Flush together with the 5th accept: Out_Count=5, slot 4 holds the word, slots 5..7=0.
- After 5 accepts, pulse Clear together with In_Valid:
  - Out_Bank=0, Out_Count=0, In_Ready=1.
  - The word on that edge is not stored.
- Deassert Resetn asynchronously (mid-clock) during FULL:
  - Out_Valid=0 and Out_Bank=0 immediately, without waiting for a clock edge.
- With WORD_PACKER_PARITY_EN, fill with 32'h0000_0001 (parity 1) and 32'h0000_0003 (parity 0) alternating:
  - Out_Parity=8'b0101_0101.
